// File: rtl/eda_img_window_ram.sv
// Frame buffer for one MxN greyscale image with registered 3x3 neighbourhood fetch.
// Optional macro EDA_IMG_RAM_EDGE_REPLICATE_EN: out-of-image slots replicate the nearest edge pixel.
//
// state    | meaning
// ST_IDLE  | no frame held, waiting for frame_start
// ST_LOAD  | accepting raster-order pixels into the buffer
// ST_SERVE | frame complete, serving window requests
module eda_img_window_ram #(
  parameter int                     M            = 16,
  parameter int                     N            = 16,
  parameter int                     PIXEL_WIDTH  = 8,
  parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE    = '0,
  parameter int                     ADDR_WIDTH   = $clog2(M*N),
  parameter int                     WINDOW_WIDTH = 9
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                frame_start,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  input  logic [PIXEL_WIDTH-1:0]              pixel_in,
  output logic                                frame_loaded,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [ADDR_WIDTH-1:0]               center_addr,
  output logic                                win_valid,
  input  logic                                win_ready,
  output logic [WINDOW_WIDTH*PIXEL_WIDTH-1:0] window_values,
  output logic [7:0]                          neigh_addr_valid,
  output logic [8*ADDR_WIDTH-1:0]             neigh_addr,
  output logic [ADDR_WIDTH-1:0]               center_out,
  output logic                                addr_err
);

  localparam int DEPTH = M * N;
  localparam int MW    = $clog2(DEPTH);
  localparam int EW    = ADDR_WIDTH + 1;
  localparam logic [EW-1:0] M_E     = EW'(M);
  localparam logic [EW-1:0] N_E     = EW'(N);
  localparam logic [EW-1:0] DEPTH_E = EW'(DEPTH);
  localparam logic [EW-1:0] ONE_E   = EW'(1);
`ifdef EDA_IMG_RAM_EDGE_REPLICATE_EN
  localparam bit REPLICATE = 1'b1;
`else
  localparam bit REPLICATE = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SERVE} state_t;
  state_t state_q, state_d;

  logic [PIXEL_WIDTH-1:0] mem [DEPTH];
  logic [MW-1:0] wr_cnt;
  logic          pix_acc, req_acc, last_pix;

  assign last_pix = (wr_cnt == MW'(DEPTH - 1));
  assign pix_acc  = (state_q == ST_LOAD) & pix_valid & ~frame_start;
  assign req_acc  = req_valid & req_ready & ~frame_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) state_d = ST_LOAD;
    else if (state_q == ST_LOAD && pix_acc && last_pix) state_d = ST_SERVE;
  end

  always_comb begin
    pix_ready    = (state_q == ST_LOAD);
    frame_loaded = (state_q == ST_SERVE);
    req_ready    = (state_q == ST_SERVE) & (~win_valid | win_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 wr_cnt <= '0;
    else if (frame_start)         wr_cnt <= '0;
    else if (pix_acc && last_pix) wr_cnt <= '0;
    else if (pix_acc)             wr_cnt <= wr_cnt + 1'b1;
  end

  // Pixel storage carries no reset; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    if (pix_acc) mem[wr_cnt] <= pixel_in;
  end

  logic [EW-1:0] c_ext, c_row, c_col;
  logic          addr_bad, up_ok, dn_ok, lf_ok, rt_ok;

  assign c_ext    = {1'b0, center_addr};
  assign c_row    = c_ext / M_E;
  assign c_col    = c_ext % M_E;
  assign addr_bad = (c_ext >= DEPTH_E);
  assign up_ok    = (c_row != '0);
  assign dn_ok    = (c_row != N_E - ONE_E);
  assign lf_ok    = (c_col != '0);
  assign rt_ok    = (c_col != M_E - ONE_E);

  logic [WINDOW_WIDTH*PIXEL_WIDTH-1:0] win_d;
  logic [7:0]                          nvalid_d;
  logic [8*ADDR_WIDTH-1:0]             naddr_d;

  // Each slot only steps along an axis that stays inside the image, so the
  // computed address is the true neighbour when valid and the clamped edge pixel otherwise.
  always_comb begin : p_window
    logic [EW-1:0] a;
    logic          row_ok, col_ok, in_ok;
    int            k;
    win_d    = '0;
    nvalid_d = '0;
    naddr_d  = '0;
    a        = '0;
    row_ok   = 1'b0;
    col_ok   = 1'b0;
    in_ok    = 1'b0;
    k        = 0;
    for (int j = 0; j < 9; j++) begin
      row_ok = (j < 3) ? up_ok : ((j > 5) ? dn_ok : 1'b1);
      col_ok = (j % 3 == 0) ? lf_ok : ((j % 3 == 2) ? rt_ok : 1'b1);
      in_ok  = row_ok & col_ok & ~addr_bad;
      a = c_ext;
      if (j < 3 && up_ok)          a = a - M_E;
      if (j > 5 && dn_ok)          a = a + M_E;
      if (j % 3 == 0 && lf_ok)     a = a - ONE_E;
      if (j % 3 == 2 && rt_ok)     a = a + ONE_E;
      if (addr_bad)                win_d[(8-j)*PIXEL_WIDTH +: PIXEL_WIDTH] = PAD_VALUE;
      else if (in_ok || REPLICATE) win_d[(8-j)*PIXEL_WIDTH +: PIXEL_WIDTH] = mem[a[MW-1:0]];
      else                         win_d[(8-j)*PIXEL_WIDTH +: PIXEL_WIDTH] = PAD_VALUE;
      if (j != 4) begin
        k = (j < 4) ? j : j - 1;
        nvalid_d[7-k] = in_ok;
        if (in_ok) naddr_d[(7-k)*ADDR_WIDTH +: ADDR_WIDTH] = a[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_valid        <= 1'b0;
      window_values    <= '0;
      neigh_addr_valid <= '0;
      neigh_addr       <= '0;
      center_out       <= '0;
      addr_err         <= 1'b0;
    end else begin
      if (frame_start || state_q != ST_SERVE) win_valid <= 1'b0;
      else if (req_acc)                       win_valid <= 1'b1;
      else if (win_ready)                     win_valid <= 1'b0;
      if (req_acc) begin
        window_values    <= win_d;
        neigh_addr_valid <= nvalid_d;
        neigh_addr       <= naddr_d;
        center_out       <= center_addr;
        addr_err         <= addr_bad;
      end
    end
  end

endmodule

// File: tb/tb_eda_img_window_ram.sv
// Directed bench for eda_img_window_ram on a 4x4 image (pixel k = k+1), with 5-bit addresses
// so that out-of-range centres are representable.
module tb_eda_img_window_ram;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_start, pix_valid, pix_ready, frame_loaded;
  logic [PW-1:0] pixel_in;
  logic          req_valid, req_ready, win_valid, win_ready, addr_err;
  logic [AW-1:0] center_addr, center_out;
  logic [9*PW-1:0] window_values;
  logic [7:0]      neigh_addr_valid;
  logic [8*AW-1:0] neigh_addr;

  int checks = 0;
  int errors = 0;

  eda_img_window_ram #(.M(M), .N(N), .PIXEL_WIDTH(PW), .PAD_VALUE(8'd0), .ADDR_WIDTH(AW), .WINDOW_WIDTH(9)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pixel_in(pixel_in), .frame_loaded(frame_loaded),
    .req_valid(req_valid), .req_ready(req_ready), .center_addr(center_addr),
    .win_valid(win_valid), .win_ready(win_ready), .window_values(window_values),
    .neigh_addr_valid(neigh_addr_valid), .neigh_addr(neigh_addr),
    .center_out(center_out), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic pulse_frame_start();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic stream(input int base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk); pix_valid = 1'b1; pixel_in = PW'(base + k);
    end
    @(negedge clk); pix_valid = 1'b0;
  endtask

  // Issues one request and returns at the first negedge after it was accepted.
  task automatic do_req(input logic [AW-1:0] a);
    int n;
    n = 0;
    @(negedge clk); req_valid = 1'b1; center_addr = a;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: req_ready=%b required 1 for centre %0d", req_ready, a);
    end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; frame_start = 0; pix_valid = 0; pixel_in = '0;
    req_valid = 0; win_ready = 1; center_addr = '0;
    repeat (2) @(negedge clk);
    checks++; if ({pix_ready, req_ready, win_valid, frame_loaded, addr_err} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {pix_ready, req_ready, win_valid, frame_loaded, addr_err}); end
    checks++; if (window_values !== '0 || neigh_addr_valid !== '0 || neigh_addr !== '0) begin errors++;
      $display("FAIL reset_data: win=%h valid=%h addr=%h required 0", window_values, neigh_addr_valid, neigh_addr); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (pix_ready !== 1'b0 || frame_loaded !== 1'b0) begin errors++;
      $display("FAIL idle_hold: pix_ready=%b frame_loaded=%b required 0 0", pix_ready, frame_loaded); end
  endtask

  task automatic test_load();
    pulse_frame_start();
    checks++; if (pix_ready !== 1'b1) begin errors++;
      $display("FAIL load_pix_ready: got %b required 1", pix_ready); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (frame_loaded !== 1'b0) begin errors++;
        $display("FAIL load_early: frame_loaded=%b before pixel %0d required 0", frame_loaded, k); end
      pix_valid = 1'b1; pixel_in = PW'(k + 1);
      @(negedge clk); pix_valid = 1'b0;
    end
    checks++; if (frame_loaded !== 1'b1 || pix_ready !== 1'b0) begin errors++;
      $display("FAIL load_done: frame_loaded=%b pix_ready=%b required 1 0", frame_loaded, pix_ready); end
  endtask

  task automatic test_center5();
    do_req(5);
    checks++; if (win_valid !== 1'b1 || center_out !== 5'd5 || addr_err !== 1'b0) begin errors++;
      $display("FAIL c5_ctrl: valid=%b centre=%0d err=%b required 1 5 0", win_valid, center_out, addr_err); end
    checks++; if (window_values !== {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}) begin errors++;
      $display("FAIL c5_values: got %h", window_values); end
    checks++; if (neigh_addr_valid !== 8'hFF) begin errors++;
      $display("FAIL c5_valid: got %b required 11111111", neigh_addr_valid); end
    checks++; if (neigh_addr !== {5'd0, 5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd9, 5'd10}) begin errors++;
      $display("FAIL c5_addr: got %h", neigh_addr); end
  endtask

  task automatic test_corner0();
    logic [9*PW-1:0] exp_w;
`ifdef EDA_IMG_RAM_EDGE_REPLICATE_EN
    exp_w = {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6};
`else
    exp_w = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
`endif
    do_req(0);
    checks++; if (neigh_addr_valid !== 8'b0000_1011) begin errors++;
      $display("FAIL c0_valid: got %b required 00001011", neigh_addr_valid); end
    checks++; if (window_values !== exp_w) begin errors++;
      $display("FAIL c0_values: got %h required %h", window_values, exp_w); end
    checks++; if (neigh_addr !== {5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd4, 5'd5}) begin errors++;
      $display("FAIL c0_addr: got %h", neigh_addr); end
  endtask

  task automatic test_right_edge();
    logic [9*PW-1:0] exp_w;
`ifdef EDA_IMG_RAM_EDGE_REPLICATE_EN
    exp_w = {8'd3, 8'd4, 8'd4, 8'd7, 8'd8, 8'd8, 8'd11, 8'd12, 8'd12};
`else
    exp_w = {8'd3, 8'd4, 8'd0, 8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0};
`endif
    do_req(7);
    checks++; if (neigh_addr_valid !== 8'b1101_0110) begin errors++;
      $display("FAIL c7_valid: got %b required 11010110", neigh_addr_valid); end
    checks++; if (neigh_addr !== {5'd2, 5'd3, 5'd0, 5'd6, 5'd0, 5'd10, 5'd11, 5'd0}) begin errors++;
      $display("FAIL c7_addr: got %h", neigh_addr); end
    checks++; if (window_values !== exp_w) begin errors++;
      $display("FAIL c7_values: got %h required %h", window_values, exp_w); end
  endtask

  task automatic test_corner15();
    logic [9*PW-1:0] exp_w;
`ifdef EDA_IMG_RAM_EDGE_REPLICATE_EN
    exp_w = {8'd11, 8'd12, 8'd12, 8'd15, 8'd16, 8'd16, 8'd15, 8'd16, 8'd16};
`else
    exp_w = {8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
    do_req(15);
    checks++; if (neigh_addr_valid !== 8'b1101_0000) begin errors++;
      $display("FAIL c15_valid: got %b required 11010000", neigh_addr_valid); end
    checks++; if (neigh_addr !== {5'd10, 5'd11, 5'd0, 5'd14, 5'd0, 5'd0, 5'd0, 5'd0}) begin errors++;
      $display("FAIL c15_addr: got %h", neigh_addr); end
    checks++; if (window_values !== exp_w) begin errors++;
      $display("FAIL c15_values: got %h required %h", window_values, exp_w); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    win_ready = 1'b0; req_valid = 1'b1; center_addr = 5'd5;
    @(negedge clk);
    checks++; if (win_valid !== 1'b1 || center_out !== 5'd5) begin errors++;
      $display("FAIL bp_first: valid=%b centre=%0d required 1 5", win_valid, center_out); end
    center_addr = 5'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0 || win_valid !== 1'b1 || center_out !== 5'd5
                    || window_values !== {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}) begin errors++;
        $display("FAIL bp_hold%0d: rdy=%b valid=%b centre=%0d win=%h", i, req_ready, win_valid, center_out, window_values); end
    end
    win_ready = 1'b1;
    @(negedge clk);
    checks++; if (win_valid !== 1'b1 || center_out !== 5'd6
                  || window_values !== {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12}) begin errors++;
      $display("FAIL b2b_c6: valid=%b centre=%0d win=%h", win_valid, center_out, window_values); end
    center_addr = 5'd9;
    @(negedge clk);
    checks++; if (win_valid !== 1'b1 || center_out !== 5'd9
                  || window_values !== {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}) begin errors++;
      $display("FAIL b2b_c9: valid=%b centre=%0d win=%h", win_valid, center_out, window_values); end
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (win_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_drain: win_valid=%b required 0", win_valid); end
  endtask

  task automatic test_addr_err();
    do_req(5'd20);
    checks++; if (addr_err !== 1'b1 || win_valid !== 1'b1 || center_out !== 5'd20) begin errors++;
      $display("FAIL err_ctrl: err=%b valid=%b centre=%0d required 1 1 20", addr_err, win_valid, center_out); end
    checks++; if (neigh_addr_valid !== 8'h00 || neigh_addr !== '0 || window_values !== '0) begin errors++;
      $display("FAIL err_data: valid=%b addr=%h win=%h required all 0", neigh_addr_valid, neigh_addr, window_values); end
  endtask

  task automatic test_frame_start();
    @(negedge clk); win_ready = 1'b1;
    @(negedge clk); win_ready = 1'b0;
    do_req(5);
    checks++; if (win_valid !== 1'b1) begin errors++;
      $display("FAIL fs_pending: win_valid=%b required 1", win_valid); end
    pulse_frame_start();
    checks++; if (win_valid !== 1'b0 || frame_loaded !== 1'b0 || pix_ready !== 1'b1 || req_ready !== 1'b0) begin errors++;
      $display("FAIL fs_drop: valid=%b loaded=%b pix_rdy=%b req_rdy=%b required 0 0 1 0",
               win_valid, frame_loaded, pix_ready, req_ready); end
    stream(50, 3);
    pulse_frame_start();
    stream(200, 16);
    checks++; if (frame_loaded !== 1'b1) begin errors++;
      $display("FAIL fs_reload: frame_loaded=%b required 1", frame_loaded); end
    win_ready = 1'b1;
    do_req(5);
    checks++; if (window_values !== {8'd200, 8'd201, 8'd202, 8'd204, 8'd205, 8'd206, 8'd208, 8'd209, 8'd210}) begin errors++;
      $display("FAIL fs_values: got %h", window_values); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_center5();
    test_corner0();
    test_right_edge();
    test_corner15();
    test_back_to_back();
    test_addr_err();
    test_frame_start();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
